// File: rtl/stack_lsu_master.sv
// Stack-aware load/store master: one request in flight, IDLE -> ACCESS -> RESP,
// with PUSH/POP managing a downward-growing stack pointer and bounds checks.
module stack_lsu_master #(
  parameter logic [7:0] SP_RESET    = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic [7:0] SP,
  output logic [7:0] Data_Address,
  output logic [7:0] Data_In,
  output logic       MemWrite,
  output logic       MemRead,
  input  logic [7:0] Data_Out
);

  localparam int unsigned DW = 8;
  localparam int unsigned OW = 2;

  localparam logic [OW-1:0] OP_LOAD  = 2'b00;
  localparam logic [OW-1:0] OP_STORE = 2'b01;
  localparam logic [OW-1:0] OP_PUSH  = 2'b10;
  localparam logic [OW-1:0] OP_POP   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [OW-1:0] r_op;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_sp;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          w_err;

  // Stack bounds are judged against the pointer as it stands at accept time
  assign w_err = ((req_op == OP_PUSH) && (r_sp < STACK_LIMIT)) ||
                 ((req_op == OP_POP)  && (r_sp == SP_RESET));

  assign SP        = r_sp;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_LOAD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_sp    <= SP_RESET;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_err   <= w_err;
            r_rdata <= '0;
          end
        end
        S_ACCESS: begin
          case (r_op)
            OP_LOAD:  r_rdata <= Data_Out;
            OP_PUSH:  r_sp    <= DW'(r_sp - 8'd1);
            OP_POP: begin
              r_rdata <= Data_Out;
              r_sp    <= DW'(r_sp + 8'd1);
            end
            default: ;
          endcase
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state and memory-port decode; strobes are forced low while rst is high
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    Data_Address = '0;
    Data_In      = '0;
    MemWrite     = 1'b0;
    MemRead      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_next = w_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        w_next = S_RESP;
        if (!rst) begin
          case (r_op)
            OP_LOAD: begin
              Data_Address = r_addr;
              MemRead      = 1'b1;
            end
            OP_STORE: begin
              Data_Address = r_addr;
              Data_In      = r_wdata;
              MemWrite     = 1'b1;
            end
            OP_PUSH: begin
              Data_Address = r_sp;
              Data_In      = r_wdata;
              MemWrite     = 1'b1;
            end
            default: begin
              Data_Address = DW'(r_sp + 8'd1);
              MemRead      = 1'b1;
            end
          endcase
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: doc/stack_lsu_master.md
STACK_LSU_MASTER -- requirements
Module: stack_lsu_master

Interface
REQ-001 Parameter SP_RESET, default 8'hFF: SP value after reset; empty-stack position.
REQ-002 Parameter STACK_LIMIT, default 8'h80: lowest address a PUSH may write.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port req_valid  input  1  request offered by the core.
REQ-006 Port req_ready  output  1  block can accept a request.
REQ-007 Port req_op  input  2  operation: 00 LOAD, 01 STORE, 10 PUSH, 11 POP.
REQ-008 Port req_addr  input  8  LOAD/STORE address; ignored for PUSH/POP.
REQ-009 Port req_wdata  input  8  STORE/PUSH data.
REQ-010 Port rsp_valid  output  1  response available.
REQ-011 Port rsp_ready  input  1  core accepts the response.
REQ-012 Port rsp_rdata  output  8  LOAD/POP read data; 0 for STORE/PUSH/error.
REQ-013 Port rsp_err  output  1  request rejected: stack overflow or underflow.
REQ-014 Port SP  output  8  current stack pointer; points to the next free slot.
REQ-015 Port Data_Address  output  8  memory data-port address.
REQ-016 Port Data_In  output  8  memory write data.
REQ-017 Port MemWrite  output  1  memory write strobe.
REQ-018 Port MemRead  output  1  memory read enable.
REQ-019 Port Data_Out  input  8  memory combinational read data.

Function
REQ-020 FSM states: IDLE, ACCESS, RESP.
REQ-021 IDLE: req_ready=1; all memory strobes low. The block accepts a request on a rising edge where req_valid=1, latches op, addr and wdata, and then transitions.
REQ-022 Accepted request with no error: go to ACCESS. With an error: go directly to RESP with rsp_err=1; no memory strobe is issued and SP is unchanged.
REQ-023 Error conditions are evaluated at accept:
  - PUSH with SP < STACK_LIMIT is an overflow.
  - POP with SP == SP_RESET is an underflow.
  - LOAD and STORE never raise an error.
REQ-024 ACCESS lasts exactly one cycle and req_ready=0. Drive the memory port from the latched request:
  - LOAD: Data_Address=addr, MemRead=1.
  - STORE: Data_Address=addr, Data_In=wdata, MemWrite=1.
  - PUSH: Data_Address=SP, Data_In=wdata, MemWrite=1.
  - POP: Data_Address=SP+1 (8-bit), MemRead=1.
REQ-025 At the end of ACCESS:
  - LOAD/POP: capture Data_Out into rsp_rdata.
  - PUSH: SP <= SP-1.
  - POP: SP <= SP+1.
  - Next state is RESP.
REQ-026 Strobes are idle outside ACCESS: MemWrite=0, MemRead=0, Data_Address=0, Data_In=0.
REQ-027 RESP: rsp_valid=1 and req_ready=0. rsp_rdata and rsp_err stay stable until a rising edge with rsp_ready=1, which moves the FSM to IDLE and clears rsp_valid, rsp_rdata and rsp_err.
REQ-028 Latency is measured from the accept edge N: ACCESS occupies cycle N+1, and rsp_valid is first high in cycle N+2. An error response is first valid in cycle N+1.
REQ-029 Throughput is at most one request per 3 cycles. A new request is accepted only in IDLE; req_valid in any other state is ignored and not queued.
REQ-030 SP boundaries:
  - SP is not modified by LOAD or STORE.
  - PUSH at SP=STACK_LIMIT succeeds, writes address STACK_LIMIT, and leaves SP=STACK_LIMIT-1.
  - A following PUSH is an overflow.
  - POP at SP=SP_RESET-1 leaves SP=SP_RESET.
  - A following POP is an underflow.
  - SP never wraps.
REQ-031 Addresses are passed unmodified; any address offset is applied by the memory.

Reset
REQ-032 While rst=1 at a rising edge, the edge forces: state IDLE, SP=SP_RESET, rsp_valid=0, rsp_rdata=0, rsp_err=0, latched request cleared.
REQ-033 MemWrite and MemRead are gated low combinationally whenever rst=1, including reset asserted during ACCESS; the interrupted request is dropped without a response.
REQ-034 In the first cycle after reset deasserts: req_ready=1, SP=8'hFF, all memory strobes low.

Verification
REQ-035 Reset, then PUSH 8'hA5 -> MemWrite=1 in cycle N+1 with Data_Address=8'hFF and Data_In=8'hA5; rsp_valid in N+2 with rsp_err=0; SP=8'hFE.
REQ-036 Following POP -> MemRead=1 with Data_Address=8'hFF; rsp_rdata=8'hA5; SP=8'hFF.
REQ-037 POP immediately after reset -> rsp_err=1 in cycle N+1; no strobe; SP stays 8'hFF; rsp_rdata=0.
REQ-038 128 PUSHes (values 0..127) -> all succeed and SP=8'h7F; 129th PUSH -> rsp_err=1, no MemWrite; then 128 POPs return 127..0 in order.
REQ-039 STORE addr=8'h10 data=8'h3C, then LOAD addr=8'h10 -> rsp_rdata=8'h3C; SP unchanged. With rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata held and req_ready=0 throughout.
REQ-040 rst pulsed during the ACCESS cycle of a PUSH -> MemWrite=0 in that cycle; no rsp_valid; SP=8'hFF; next request is accepted normally.
